// File: rtl/cpu_defs.sv
// Definitions shared by the fetch stage and the instruction decoder/controller:
// opcode values, sequencer state encoding and the default address width.
package cpu_defs;

    localparam int ADDR_W_DEF = 5;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select for the end of an EXEC cycle; priority is halt, then jump,
// then a taken skip, then sequential increment (all modulo 2^ADDR_W).
module pc_next #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] operand_addr,
    input  logic              jump,
    input  logic              skip,
    input  logic              acc_zero,
    input  logic              halt,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc + ADDR_W'(1);
        if (halt) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = operand_addr;
        end else if (skip && acc_zero) begin
            next_pc = pc + ADDR_W'(2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: program counter, instruction register and
// the FETCH/DECODE/EXEC/HALTED sequencer that gates datapath commits.
//
// state  | meaning
// FETCH  | imem_addr = pc; ir loads imem_data at the edge
// DECODE | opcode/operand_addr stable; controller samples them on the negedge
// EXEC   | exec_en high; pc updated from halt/jump/skip at the edge
// HALTED | halted high; pc holds the HLT address until resume
module fetch_unit
    import cpu_defs::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [ADDR_W+2:0]   imem_data,
    output logic [2:0]          opcode,
    output logic [ADDR_W-1:0]   operand_addr,
    input  logic                jump,
    input  logic                skip,
    input  logic                halt,
    input  logic                acc_zero,
    input  logic                resume,
    output logic                exec_en,
    output logic                halted,
    output logic [ADDR_W-1:0]   pc
);

    localparam int IR_W = ADDR_W + 3;

    state_t            state;
    state_t            state_nxt;
    logic [IR_W-1:0]   ir;
    logic              ir_load;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_exec;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc           (pc),
        .operand_addr (operand_addr),
        .jump         (jump),
        .skip         (skip),
        .acc_zero     (acc_zero),
        .halt         (halt),
        .next_pc      (pc_exec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Controller inputs only matter in EXEC; resume only in HALTED.
    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_d      = pc_exec;
        case (state)
            ST_FETCH: begin
                ir_load   = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                pc_load   = 1'b1;
                state_nxt = halt ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: begin
                if (resume) begin
                    pc_load   = 1'b1;
                    pc_d      = pc + ADDR_W'(1);
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
            ir <= '0;
        end else begin
            if (pc_load) begin
                pc <= pc_d;
            end
            if (ir_load) begin
                ir <= imem_data;
            end
        end
    end

    assign imem_addr    = pc;
    assign opcode       = ir[IR_W-1:ADDR_W];
    assign operand_addr = ir[ADDR_W-1:0];
    assign exec_en      = (state == ST_EXEC);
    assign halted       = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the controller and the
// instruction memory, and an instruction-level model is compared every cycle.
module tb_fetch_unit;
    import cpu_defs::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] imem_addr;
    logic [7:0] imem_data;
    logic [2:0] opcode;
    logic [4:0] operand_addr;
    logic       jump, skip, halt, acc_zero, resume;
    logic       exec_en, halted;
    logic [4:0] pc;

    logic [7:0] imem [32];
    assign imem_data = imem[imem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.ADDR_W(5), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .opcode       (opcode),
        .operand_addr (operand_addr),
        .jump         (jump),
        .skip         (skip),
        .halt         (halt),
        .acc_zero     (acc_zero),
        .resume       (resume),
        .exec_en      (exec_en),
        .halted       (halted),
        .pc           (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    // Instruction-level model: phase 0..2 walk one instruction, 3 is halted.
    int         m_pc;
    int         m_phase;
    logic [7:0] m_ir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    = 0;
            m_phase = 0;
            m_ir    = 8'h00;
        end else begin
            case (m_phase)
                0: begin
                    m_ir    = imem[m_pc];
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: begin
                    if (halt) begin
                        m_phase = 3;
                    end else begin
                        if (jump)                  m_pc = int'(m_ir[4:0]);
                        else if (skip && acc_zero) m_pc = (m_pc + 2) % 32;
                        else                       m_pc = (m_pc + 1) % 32;
                        m_phase = 0;
                    end
                end
                default: begin
                    if (resume) begin
                        m_pc    = (m_pc + 1) % 32;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("pc", 32'(pc), 32'(m_pc));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("opcode", 32'(opcode), 32'(m_ir[7:5]));
        chk("operand_addr", 32'(operand_addr), 32'(m_ir[4:0]));
        chk("exec_en", 32'(exec_en), 32'(m_phase == 2));
        chk("halted", 32'(halted), 32'(m_phase == 3));
    end

    // Entered at FETCH+2ns; stale controller outputs are asserted outside EXEC,
    // and resume is held high throughout, including the EXEC cycle.
    task automatic run_instr(input logic j, input logic s, input logic h,
                             input logic az, input int exp_op);
        jump = 1'b1; skip = 1'b1; halt = 1'b1; acc_zero = 1'b1; resume = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        jump = j; skip = s; halt = h; acc_zero = az;
        chk("exec_in_exec", 32'(exec_en), 32'd1);
        chk("exec_operand", 32'(operand_addr), 32'(exp_op));
        @(posedge clk); #2;
        jump = 1'b0; skip = 1'b0; halt = 1'b0; acc_zero = 1'b0; resume = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 8'h00;
        imem[0] = ins(OP_JMP, 5'd7);
        imem[7] = ins(OP_ADD, 5'd3);
        rst_n = 1'b0;
        jump = 1'b0; skip = 1'b0; halt = 1'b0; acc_zero = 1'b0; resume = 1'b0;
        #23;
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_opcode", 32'(opcode), 32'd0);
        chk("reset_exec_en", 32'(exec_en), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        #4 rst_n = 1'b1;

        // Reach pc=7, then reset in the middle of DECODE
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 7);
        @(posedge clk); #2;
        chk("decode_pc", 32'(pc), 32'd7);
        chk("decode_opcode", 32'(opcode), 32'(OP_ADD));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_opcode", 32'(opcode), 32'd0);
        chk("async_rst_exec_en", 32'(exec_en), 32'd0);
        imem[0] = ins(OP_LDA, 5'd5);
        imem[1] = ins(OP_ADD, 5'd6);
        imem[2] = ins(OP_STO, 5'd7);
        imem[3] = ins(OP_JMP, 5'd20);
        @(posedge clk); #2 rst_n = 1'b1;
        chk("first_fetch_addr", 32'(imem_addr), 32'd0);

        // Straight-line
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 5);
        chk("line_pc1", 32'(pc), 32'd1);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 6);
        chk("line_pc2", 32'(pc), 32'd2);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 7);
        chk("line_pc3", 32'(pc), 32'd3);
        chk("model_pc3", 32'(m_pc), 32'd3);

        // Jump beats skip
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 20);
        chk("jump_pc", 32'(pc), 32'd20);
        chk("jump_imem_addr", 32'(imem_addr), 32'd20);

        // Skip taken and not taken at pc=31
        imem[20] = ins(OP_JMP, 5'd31);
        imem[31] = ins(OP_SKZ, 5'd0);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 31);
        chk("to31_pc", 32'(pc), 32'd31);
        run_instr(1'b0, 1'b1, 1'b0, 1'b1, 0);
        chk("skip_wrap_pc", 32'(pc), 32'd1);
        chk("model_skip_wrap", 32'(m_pc), 32'd1);
        imem[1] = ins(OP_JMP, 5'd31);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 31);
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("noskip_wrap_pc", 32'(pc), 32'd0);

        // Halt at 9, idle, resume
        imem[0] = ins(OP_JMP, 5'd9);
        imem[9] = ins(OP_HLT, 5'd0);
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 9);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd9);
        repeat (10) begin
            @(posedge clk); #2;
            chk("idle_exec_en", 32'(exec_en), 32'd0);
            chk("idle_pc", 32'(pc), 32'd9);
        end
        resume = 1'b1;
        @(posedge clk); #2;
        resume = 1'b0;
        chk("resume_pc", 32'(pc), 32'd10);
        chk("resume_halted", 32'(halted), 32'd0);

        // Halt beats jump
        imem[10] = ins(OP_HLT, 5'd3);
        imem[11] = ins(OP_LDA, 5'd1);
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 3);
        chk("haltpri_halted", 32'(halted), 32'd1);
        chk("haltpri_pc", 32'(pc), 32'd10);
        @(posedge clk); #2;
        resume = 1'b1;
        @(posedge clk); #2;
        resume = 1'b0;
        chk("resume2_pc", 32'(pc), 32'd11);

        // Reset in the middle of EXEC
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("pre_rst_exec_en", 32'(exec_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("exec_rst_exec_en", 32'(exec_en), 32'd0);
        chk("exec_rst_pc", 32'(pc), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
